// File: rtl/sprite_attr_ram.sv
// Sprite attribute RAM: byte-enabled write port, registered read port and a clear sequencer.
// Define SPRITE_ATTR_RAM_BYPASS_EN for write-first collisions (read-first otherwise).
module sprite_attr_ram #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [DATA_W-1:0] CLEAR_WORD = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_start_i,
  output logic                busy_o,
  output logic                clr_done_o,
  input  logic                wr_en_i,
  input  logic [DATA_W/8-1:0] ben_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o
);

  localparam int unsigned    NUM_BYTES = DATA_W / 8;
  localparam int unsigned    DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              clr_done_q, clr_done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [NUM_BYTES-1:0] mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rd_word;
  logic [DATA_W-1:0]    rd_word;

  assign mem_rd_word = mem[rd_addr_i];

`ifdef SPRITE_ATTR_RAM_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = wr_en_i && (wr_addr_i == rd_addr_i);

  // Write-first: enabled lanes of a colliding write replace the stored bytes.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bypass
    assign rd_word[8*gi +: 8] = (bypass_hit && ben_i[gi]) ? wr_data_i[8*gi +: 8]
                                                          : mem_rd_word[8*gi +: 8];
  end
`else
  assign rd_word = mem_rd_word;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    mem_we     = '0;
    mem_waddr  = wr_addr_i;
    mem_wdata  = wr_data_i;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = '1;
        mem_waddr = cnt_q[ADDR_W-1:0];
        mem_wdata = CLEAR_WORD;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: begin
        if (wr_en_i) mem_we = ben_i;
        if (rd_en_i) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_word;
        end
        // A write in the same cycle still lands; the clear then overwrites it.
        if (clr_start_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
    if (rst_i) mem_we = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      clr_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage has no reset; the clear sequencer initialises it.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (mem_we[k]) mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  assign busy_o     = busy_q;
  assign clr_done_o = clr_done_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_sprite_attr_ram.sv
// Directed bench for sprite_attr_ram: a 32x256 instance and a 64x16 instance.
module tb_sprite_attr_ram;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        a_rst, a_clr_start, a_busy, a_clr_done, a_wr_en, a_rd_en, a_rd_valid;
  logic [3:0]  a_ben;
  logic [7:0]  a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data, a_rd_data;

  logic        b_rst, b_clr_start, b_busy, b_clr_done, b_wr_en, b_rd_en, b_rd_valid;
  logic [7:0]  b_ben;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [63:0] b_wr_data, b_rd_data;

  sprite_attr_ram #(.DATA_W(32), .ADDR_W(8), .CLEAR_WORD(32'hDEADBEEF)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .clr_start_i(a_clr_start), .busy_o(a_busy),
    .clr_done_o(a_clr_done), .wr_en_i(a_wr_en), .ben_i(a_ben), .wr_addr_i(a_wr_addr),
    .wr_data_i(a_wr_data), .rd_en_i(a_rd_en), .rd_addr_i(a_rd_addr),
    .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid)
  );

  sprite_attr_ram #(.DATA_W(64), .ADDR_W(4), .CLEAR_WORD(64'h0123456789ABCDEF)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .clr_start_i(b_clr_start), .busy_o(b_busy),
    .clr_done_o(b_clr_done), .wr_en_i(b_wr_en), .ben_i(b_ben), .wr_addr_i(b_wr_addr),
    .wr_data_i(b_wr_data), .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr),
    .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] ben);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_ben = ben;
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic a_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    a_rd_en = 1'b1; a_rd_addr = addr;
    tick();
    a_rd_en = 1'b0;
    check({tag, "_valid"}, {63'd0, a_rd_valid}, 64'd1);
    check(tag, {32'd0, a_rd_data}, {32'd0, exp});
  endtask

  // Counts edges until dut_a leaves CLEAR, bounded so a stuck sequencer still ends the run.
  task automatic a_wait_clear(output int cycles, output int dones);
    cycles = 0;
    dones  = 0;
    while (cycles < 400) begin
      tick();
      cycles++;
      if (a_clr_done) dones++;
      if (!a_busy) break;
    end
  endtask

  int cycles, dones, b_fall, b_dones, pre_dones;

  initial begin
    a_rst = 1'b1; a_clr_start = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    a_ben = '0; a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0;
    b_rst = 1'b1; b_clr_start = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    b_ben = '0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;
    repeat (3) tick();

    check("rst_busy",     {63'd0, a_busy},     64'd1);
    check("rst_clr_done", {63'd0, a_clr_done}, 64'd0);
    check("rst_rd_valid", {63'd0, a_rd_valid}, 64'd0);
    check("rst_rd_data",  {32'd0, a_rd_data},  64'd0);

    // Reset release: both instances clear in parallel.
    a_rst = 1'b0;
    b_rst = 1'b0;
    cycles = 0; dones = 0; b_fall = 0; b_dones = 0;
    while (cycles < 400) begin
      tick();
      cycles++;
      if (a_clr_done) dones++;
      if (b_clr_done) b_dones++;
      if (!b_busy && b_fall == 0) b_fall = cycles;
      if (!a_busy) break;
    end
    check("clear_cycles",     cycles, 256);
    check("clear_done_count", dones, 1);
    check("clear_done_last",  {63'd0, a_clr_done}, 64'd1);
    check("b_clear_cycles",   b_fall, 16);
    check("b_clear_done",     b_dones, 1);
    tick();
    check("done_one_pulse", {63'd0, a_clr_done}, 64'd0);
    check("idle_no_valid",  {63'd0, a_rd_valid}, 64'd0);

    a_read("clr_rd0",   8'd0,   32'hDEADBEEF);
    a_read("clr_rd128", 8'd128, 32'hDEADBEEF);
    a_read("clr_rd255", 8'd255, 32'hDEADBEEF);

    // Byte enables on a zeroed word.
    a_write(8'd5, 32'h0000_0000, 4'b1111);
    a_write(8'd5, 32'h1122_3344, 4'b0101);
    a_read("ben_rd5", 8'd5, 32'h0022_0044);
    a_write(8'd5, 32'hFFFF_FFFF, 4'b0000);
    a_read("ben_zero", 8'd5, 32'h0022_0044);

    // Same-cycle write/read to the same address.
    a_write(8'd9, 32'hAAAA_AAAA, 4'b1111);
    a_wr_en = 1'b1; a_wr_addr = 8'd9; a_wr_data = 32'h5555_5555; a_ben = 4'b0011;
    a_rd_en = 1'b1; a_rd_addr = 8'd9;
    tick();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    check("coll_valid", {63'd0, a_rd_valid}, 64'd1);
`ifdef SPRITE_ATTR_RAM_BYPASS_EN
    check("coll_data", {32'd0, a_rd_data}, {32'd0, 32'hAAAA_5555});
`else
    check("coll_data", {32'd0, a_rd_data}, {32'd0, 32'hAAAA_AAAA});
`endif
    a_read("coll_next", 8'd9, 32'hAAAA_5555);

    // Different-address write and read in one cycle.
    a_wr_en = 1'b1; a_wr_addr = 8'd20; a_wr_data = 32'h1234_5678; a_ben = 4'b1111;
    a_rd_en = 1'b1; a_rd_addr = 8'd5;
    tick();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    check("indep_rd", {32'd0, a_rd_data}, {32'd0, 32'h0022_0044});
    a_read("indep_wr", 8'd20, 32'h1234_5678);

    // Accesses while clearing are dropped and read data holds.
    a_clr_start = 1'b1;
    tick();
    a_clr_start = 1'b0;
    check("clr_busy", {63'd0, a_busy}, 64'd1);
    a_wr_en = 1'b1; a_wr_addr = 8'd3; a_wr_data = 32'd1; a_ben = 4'b1111;
    a_rd_en = 1'b1; a_rd_addr = 8'd3;
    tick();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    check("busy_no_valid", {63'd0, a_rd_valid}, 64'd0);
    check("busy_rd_hold",  {32'd0, a_rd_data}, {32'd0, 32'h1234_5678});
    a_wait_clear(cycles, dones);
    check("req_clear_cycles", cycles + 1, 256);
    check("req_clear_done",   dones, 1);
    a_read("clr_addr3",  8'd3,  32'hDEADBEEF);
    a_read("clr_addr20", 8'd20, 32'hDEADBEEF);

    // Reset at clear count 100 restarts the sequence.
    a_clr_start = 1'b1;
    tick();
    a_clr_start = 1'b0;
    pre_dones = 0;
    repeat (100) begin
      tick();
      if (a_clr_done) pre_dones++;
    end
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    check("mid_rst_busy",    {63'd0, a_busy},     64'd1);
    check("mid_rst_done",    {63'd0, a_clr_done}, 64'd0);
    check("mid_rst_rd_data", {32'd0, a_rd_data},  64'd0);
    a_wait_clear(cycles, dones);
    check("mid_rst_cycles", cycles, 256);
    check("mid_rst_dones",  pre_dones + dones, 1);
    a_read("mid_rst_rd", 8'd77, 32'hDEADBEEF);

    // 64-bit instance: only the top byte lane is written.
    b_wr_en = 1'b1; b_wr_addr = 4'd2; b_wr_data = 64'hFFFF_FFFF_FFFF_FFFF; b_ben = 8'h80;
    tick();
    b_wr_en = 1'b0;
    b_rd_en = 1'b1; b_rd_addr = 4'd2;
    tick();
    check("b_ben_valid", {63'd0, b_rd_valid}, 64'd1);
    check("b_ben_data",  b_rd_data, 64'hFF23_4567_89AB_CDEF);
    b_rd_addr = 4'd15;
    tick();
    b_rd_en = 1'b0;
    check("b_rd15", b_rd_data, 64'h0123_4567_89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
